// File: rtl/pixel_compositor.sv
// Per-pixel colour stage: resolves the winning overlay layer by fixed priority,
// applies per-layer blink, then looks it up in a writable palette with optional invert.
module pixel_compositor #(
  parameter int LAYERS        = 6,
  parameter int COLOR_BITS    = 8,
  parameter int BLINK_BITS    = 5,
  parameter int PAL_ADDR_BITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic                      pix_valid,
  input  logic [LAYERS-1:0]         layer_on,
  input  logic [LAYERS-1:0]         blink_en,
  input  logic                      invert,
  input  logic                      pal_we,
  input  logic [PAL_ADDR_BITS-1:0]  pal_addr,
  input  logic [3*COLOR_BITS-1:0]   pal_data,
  output logic                      out_valid,
  output logic [COLOR_BITS-1:0]     r,
  output logic [COLOR_BITS-1:0]     g,
  output logic [COLOR_BITS-1:0]     b,
  output logic                      hit_any,
  output logic [PAL_ADDR_BITS-1:0]  hit_layer
);

  localparam int CW = 3 * COLOR_BITS;
  localparam logic [PAL_ADDR_BITS-1:0] BG_IDX = PAL_ADDR_BITS'(LAYERS);
  localparam logic [CW-1:0] WHITE = {CW{1'b1}};
  localparam logic [CW-1:0] BLUE  = {{(2*COLOR_BITS){1'b0}}, {COLOR_BITS{1'b1}}};
  localparam logic [CW-1:0] BLACK = {CW{1'b0}};

  function automatic logic [CW-1:0] default_entry(input int idx);
    logic [CW-1:0] e;
    if (idx == 0) begin
      e = BLUE;
    end else if (idx == LAYERS) begin
      e = WHITE;
    end else begin
      e = BLACK;
    end
    return e;
  endfunction

  logic [BLINK_BITS-1:0]    frame_cnt_r;
  logic [CW-1:0]            pal_r [0:LAYERS];
  logic                     blink_phase_s;
  logic [LAYERS-1:0]        eligible_s;
  logic [PAL_ADDR_BITS-1:0] win_idx_s;
  logic                     win_hit_s;
  logic                     s1_valid_r;
  logic [PAL_ADDR_BITS-1:0] s1_idx_r;
  logic                     s1_hit_r;
  logic                     s1_inv_r;
  logic [CW-1:0]            rd_s;
  logic [CW-1:0]            col_s;

  assign blink_phase_s = frame_cnt_r[BLINK_BITS-1];
  assign eligible_s    = layer_on & ~(blink_en & {LAYERS{blink_phase_s}});

  // Frame counter; wraps naturally at its width
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_r <= {BLINK_BITS{1'b0}};
    end else if (frame_start) begin
      frame_cnt_r <= frame_cnt_r + {{(BLINK_BITS-1){1'b0}}, 1'b1};
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  // Priority resolve: scanning high to low leaves the lowest eligible index
  always_comb begin
    win_idx_s = BG_IDX;
    win_hit_s = 1'b0;
    for (int i = LAYERS - 1; i >= 0; i--) begin
      if (eligible_s[i]) begin
        win_idx_s = PAL_ADDR_BITS'(i);
        win_hit_s = 1'b1;
      end else begin
        win_idx_s = win_idx_s;
        win_hit_s = win_hit_s;
      end
    end
  end

  // Palette storage; out-of-range addresses are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= LAYERS; i++) begin
        pal_r[i] <= default_entry(i);
      end
    end else if (pal_we && (pal_addr <= BG_IDX)) begin
      pal_r[pal_addr] <= pal_data;
    end else begin
      pal_r <= pal_r;
    end
  end

  // Stage 1: latch winner and invert mode alongside the valid bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_r <= 1'b0;
      s1_idx_r   <= {PAL_ADDR_BITS{1'b0}};
      s1_hit_r   <= 1'b0;
      s1_inv_r   <= 1'b0;
    end else begin
      s1_valid_r <= pix_valid;
      if (pix_valid) begin
        s1_idx_r <= win_idx_s;
        s1_hit_r <= win_hit_s;
        s1_inv_r <= invert;
      end else begin
        s1_idx_r <= s1_idx_r;
        s1_hit_r <= s1_hit_r;
        s1_inv_r <= s1_inv_r;
      end
    end
  end

  // Read sees the pre-write entry because the palette updates on the same edge
  assign rd_s  = pal_r[s1_idx_r];
  assign col_s = s1_inv_r ? ~rd_s : rd_s;

  // Stage 2: registered colour outputs, held across bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      r         <= {COLOR_BITS{1'b0}};
      g         <= {COLOR_BITS{1'b0}};
      b         <= {COLOR_BITS{1'b0}};
      hit_any   <= 1'b0;
      hit_layer <= {PAL_ADDR_BITS{1'b0}};
    end else begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        {r, g, b} <= col_s;
        hit_any   <= s1_hit_r;
        hit_layer <= s1_idx_r;
      end else begin
        {r, g, b} <= {r, g, b};
        hit_any   <= hit_any;
        hit_layer <= hit_layer;
      end
    end
  end

endmodule

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
Parametrised, pipelined successor to the per-pixel colour stage.
- Takes LAYERS per-pixel "on" flags (notes, staff lines, clock, titles, UI, …) from the overlay generators and resolves the winning layer by fixed priority.
- Looks the winner up in a runtime-writable palette, with per-layer blink and a global invert mode.
- Drives registered r/g/b to the VGA output path with a valid strobe.

Parameters:
LAYERS, 6, number of overlay layers; index 0 = highest priority
COLOR_BITS, 8, bits per colour channel
BLINK_BITS, 5, frame counter width; blink phase = counter MSB (toggles every 2^(BLINK_BITS-1) frames)
PAL_ADDR_BITS, 3, palette address width; must satisfy 2^PAL_ADDR_BITS >= LAYERS+1

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous, active-low reset
frame_start  input  1  one-cycle pulse per frame (issued during blanking)
pix_valid  input  1  layer_on is valid this cycle
layer_on  input  LAYERS  per-layer pixel-on flags for current pixel
blink_en  input  LAYERS  per-layer blink enable (static, sampled in stage 1)
invert  input  1  global invert mode (sampled in stage 1)
pal_we  input  1  palette write strobe
pal_addr  input  PAL_ADDR_BITS  0..LAYERS-1 = layer colour, LAYERS = background
pal_data  input  3*COLOR_BITS  {r,g,b} colour to write
out_valid  output  1  r/g/b/hit_* valid
r  output  COLOR_BITS  red
g  output  COLOR_BITS  green
b  output  COLOR_BITS  blue
hit_any  output  1  some layer won the pixel
hit_layer  output  PAL_ADDR_BITS  winning layer index (LAYERS when background)

Behaviour:
- Reset (rst=0, async):
  - out_valid=0, r=g=b=0, hit_any=0, hit_layer=0.
  - Frame counter=0; pipeline valid bits=0.
  - Palette reverts to defaults: entry 0 = {0,0,all-ones} (blue), entries 1..LAYERS-1 = 0 (black), entry LAYERS = all-ones (white).
  - Reset mid-pipeline discards in-flight pixels; no out_valid pulse for them.
- Frame counter:
  - Increments by 1 on each frame_start and wraps at 2^BLINK_BITS.
  - blink_phase = counter[BLINK_BITS-1].
- Stage 1 (cycle after pix_valid):
  - eligible[i] = layer_on[i] & ~(blink_en[i] & blink_phase).
  - Winner = lowest i with eligible[i]; none eligible → background (index LAYERS, hit_any=0).
  - Registers winner index, hit_any and invert together with valid.
  - If frame_start and pix_valid coincide, the pixel uses the pre-increment blink_phase.
- Stage 2 (next cycle): palette read at the stage-1 winner index.
  - Colour = entry, or bitwise NOT of entry if the staged invert is 1.
  - Registers r/g/b, hit_any, hit_layer; out_valid = staged valid.
- Latency: exactly 2 clk cycles from pix_valid to out_valid.
  - Throughput: 1 pixel/cycle; back-to-back pix_valid is supported with no bubbles.
- pix_valid=0: the bubble propagates. out_valid=0 two cycles later; r/g/b/hit_* hold their previous values.
- Palette writes:
  - Synchronous on clk when pal_we=1.
  - pal_addr > LAYERS: write ignored, no entry changed.
  - Write and stage-2 read of the same entry in the same cycle: the read returns the OLD value. The new value is visible from the next cycle.
- Width rules: no arithmetic on colours; the counter wraps modulo 2^BLINK_BITS.
- Unused palette addresses (> LAYERS) are never read.

Test Plan:
- Reset then 3 back-to-back pixels:
  - layer_on=6'b000000 → out_valid high cycles 2–4, first pixel rgb=FFFFFF, hit_any=0, hit_layer=6.
  - layer_on=6'b000001 → rgb=0000FF, hit_layer=0.
  - layer_on=6'b000010 → rgb=000000, hit_layer=1.
- Priority: layer_on=6'b101100 → hit_layer=2.
  - After pal write addr=2 data=FF0000 (≥1 cycle earlier), rgb=FF0000.
- Blink (BLINK_BITS=5): blink_en=6'b000001, layer_on=6'b000001.
  - Frames 0–15 → rgb=0000FF.
  - After 16 frame_start pulses → background FFFFFF.
  - After 32 pulses (wrap) → 0000FF again.
  - Coincident frame_start on 16th pulse with pix_valid → that pixel still 0000FF.
- Invert: invert=1, layer_on=0 → rgb=000000. pal_addr=7 write → no palette change.
- Same-cycle write/read hazard: write addr=6 data=123456 in the cycle that pixel's stage 2 reads entry 6 → output FFFFFF; next background pixel → 123456.
- Reset mid-stream: rst low for 1 cycle with 2 pixels in flight.
  - Outputs go 0 immediately, no out_valid for in-flight pixels.
  - Palette entry 2 back to 000000.
